pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter ADDR_WIDTH, default 32: width of the program counter and redirect target.
REQ-003 Parameter RESET_VECTOR, default 32'h00000000: first fetch address after reset, truncated to ADDR_WIDTH.
REQ-004 Parameter INST_BYTES, default 4: sequential increment; power of two, 1..16.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-007 Port stall_i  input  1  pipeline stall; holds the PC and suppresses fetch.
REQ-008 Port br_valid_i  input  1  redirect request (branch/jump) valid for this cycle.
REQ-009 Port br_target_i  input  ADDR_WIDTH  redirect target address.
REQ-010 Port req_ready_i  input  1  instruction memory accepts the current fetch.
REQ-011 Port pc_o  output  ADDR_WIDTH  current fetch address, registered.
REQ-012 Port ce_o  output  1  fetch request valid (chip enable), registered.
REQ-013 Port misalign_o  output  1  one-cycle pulse: last accepted redirect target was misaligned.

Function
REQ-014 The FSM SHALL have three states: BOOT, RUN, STALL; ce_o SHALL be 1 only in RUN.
REQ-015 BOOT SHALL last exactly one clock edge after reset release, then move to RUN with pc_o = RESET_VECTOR.
REQ-016 A fetch SHALL be accepted on an edge where state = RUN, req_ready_i = 1, stall_i = 0, br_valid_i = 0; pc_o SHALL then become pc_o + INST_BYTES.
REQ-017 In RUN with req_ready_i = 0 and stall_i = 0, pc_o and ce_o SHALL hold (retry the same address).
REQ-018 In RUN with stall_i = 1 and br_valid_i = 0, pc_o SHALL hold and state SHALL move to STALL (ce_o = 0 next cycle).
REQ-019 In STALL, state SHALL return to RUN on the first edge with stall_i = 0; pc_o holds until then.
REQ-020 br_valid_i = 1 SHALL have highest priority in RUN and STALL: pc_o <= aligned target on that edge, regardless of stall_i and req_ready_i.
REQ-021 On a redirect the state SHALL be STALL if stall_i = 1, else RUN; the in-flight sequential increment is discarded.
REQ-022 br_valid_i SHALL be ignored in BOOT.
REQ-023 Aligned target SHALL be br_target_i with its low log2(INST_BYTES) bits cleared.
REQ-024 misalign_o SHALL be 1 for exactly the cycle after a redirect whose cleared bits were non-zero, else 0.
REQ-025 PC increment SHALL wrap modulo 2^ADDR_WIDTH with no flag.
REQ-026 Fetch-acceptance latency SHALL be zero cycles: the new pc_o is visible the cycle after the accepting edge.

Reset
REQ-027 While rst = 0: pc_o = RESET_VECTOR, ce_o = 0, misalign_o = 0, state = BOOT, immediately and without a clock edge.
REQ-028 Assertion of rst mid-fetch, mid-stall or mid-redirect SHALL abandon all pending activity; no request state survives reset.

Verification
REQ-029 Release rst, req_ready_i = 1 held -> ce_o 0 for one cycle, then pc_o 0x0, 0x4, 0x8, 0xC on consecutive cycles.
REQ-030 In RUN at pc 0x10, req_ready_i = 0 for 3 cycles -> pc_o stays 0x10, ce_o = 1; then ready = 1 -> 0x14.
REQ-031 At pc 0x20, stall_i = 1 for 2 cycles -> ce_o 0 from next cycle, pc_o 0x20; stall_i = 0 -> ce_o 1, pc_o 0x20, then 0x24.
REQ-032 br_valid_i = 1, target 0x103, stall_i = 1, req_ready_i = 1 -> pc_o 0x100, misalign_o pulses 1 for one cycle, state STALL.
REQ-033 pc_o = 0xFFFFFFFC, fetch accepted -> pc_o 0x00000000, ce_o stays 1.
REQ-034 rst driven 0 asynchronously between edges while pc_o = 0x40 -> pc_o 0x0 and ce_o 0 before the next edge; release repeats REQ-029.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-side signal bundle for pc_gen: redirect/stall controls in, fetch address and enable out.
// The master modport is the PC generator; the slave modport is the pipeline/memory side.
interface pc_gen_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  stall_i;
  logic                  br_valid_i;
  logic [ADDR_WIDTH-1:0] br_target_i;
  logic                  req_ready_i;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  ce_o;
  logic                  misalign_o;

  modport master (
    input  stall_i,
    input  br_valid_i,
    input  br_target_i,
    input  req_ready_i,
    output pc_o,
    output ce_o,
    output misalign_o
  );

  modport slave (
    output stall_i,
    output br_valid_i,
    output br_target_i,
    output req_ready_i,
    input  pc_o,
    input  ce_o,
    input  misalign_o
  );

endinterface

// File: rtl/pc_gen.sv
// Program counter generator: BOOT/RUN/STALL FSM producing a registered fetch address and
// chip enable, with highest-priority branch redirect and a one-cycle misaligned-target pulse.
module pc_gen #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned INST_BYTES   = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] OffMask = ADDR_WIDTH'(INST_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] PcInc   = ADDR_WIDTH'(INST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ResetPc = ADDR_WIDTH'(RESET_VECTOR);

  typedef enum logic [1:0] {StBoot, StRun, StStall} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  ce_q, ce_d;
  logic                  misalign_q, misalign_d;

  logic [ADDR_WIDTH-1:0] aligned_tgt;
  logic                  tgt_misaligned;

  assign aligned_tgt    = bus.br_target_i & ~OffMask;
  assign tgt_misaligned = |(bus.br_target_i & OffMask);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
        pc_d    = ResetPc;
      end
      StRun, StStall: begin
        if (bus.br_valid_i) begin
          // Redirect wins over stall and ready; any pending increment is dropped.
          pc_d       = aligned_tgt;
          misalign_d = tgt_misaligned;
          state_d    = bus.stall_i ? StStall : StRun;
        end else if (bus.stall_i) begin
          state_d = StStall;
        end else if (state_q == StStall) begin
          state_d = StRun;
        end else if (bus.req_ready_i) begin
          pc_d = pc_q + PcInc;
        end
      end
      default: state_d = StBoot;
    endcase
    ce_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StBoot;
      pc_q       <= ResetPc;
      ce_q       <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ce_q       <= ce_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.ce_o       = ce_q;
  assign bus.misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: boot sequence, retry, stall, redirects, wrap and async reset.
module tb_pc_gen;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_gen_if #(.ADDR_WIDTH(32)) bus ();

  pc_gen #(
    .ADDR_WIDTH  (32),
    .RESET_VECTOR(32'h0000_0000),
    .INST_BYTES  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic ce,
                         input logic mis);
    chk({tag, ".pc"}, bus.pc_o, pc);
    chk({tag, ".ce"}, {31'b0, bus.ce_o}, {31'b0, ce});
    chk({tag, ".mis"}, {31'b0, bus.misalign_o}, {31'b0, mis});
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b0;
    bus.stall_i      = 1'b0;
    bus.br_valid_i   = 1'b0;
    bus.br_target_i  = 32'h0;
    bus.req_ready_i  = 1'b1;

    // Reset state, then boot with ready held high.
    #2;
    chk_out("reset", 32'h0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk_out("boot", 32'h0, 1'b0, 1'b0);
    step(); chk_out("seq0", 32'h0, 1'b1, 1'b0);
    step(); chk_out("seq4", 32'h4, 1'b1, 1'b0);
    step(); chk_out("seq8", 32'h8, 1'b1, 1'b0);
    step(); chk_out("seqc", 32'hC, 1'b1, 1'b0);
    step(); chk_out("seq10", 32'h10, 1'b1, 1'b0);

    // Not-ready retry holds address with ce asserted.
    bus.req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("retry", 32'h10, 1'b1, 1'b0);
    end
    bus.req_ready_i = 1'b1;
    step(); chk_out("retry_go", 32'h14, 1'b1, 1'b0);
    step(); step(); step();
    chk_out("at20", 32'h20, 1'b1, 1'b0);

    // Two-cycle stall.
    bus.stall_i = 1'b1;
    step(); chk_out("stall1", 32'h20, 1'b0, 1'b0);
    step(); chk_out("stall2", 32'h20, 1'b0, 1'b0);
    bus.stall_i = 1'b0;
    step(); chk_out("unstall", 32'h20, 1'b1, 1'b0);
    step(); chk_out("unstall_inc", 32'h24, 1'b1, 1'b0);

    // Misaligned redirect while stalling.
    bus.br_valid_i  = 1'b1;
    bus.br_target_i = 32'h103;
    bus.stall_i     = 1'b1;
    step(); chk_out("br_mis", 32'h100, 1'b0, 1'b1);
    bus.br_valid_i = 1'b0;
    step(); chk_out("br_mis_after", 32'h100, 1'b0, 1'b0);
    bus.stall_i = 1'b0;
    step(); chk_out("br_resume", 32'h100, 1'b1, 1'b0);
    step(); chk_out("br_resume_inc", 32'h104, 1'b1, 1'b0);

    // Aligned redirect in RUN.
    bus.br_valid_i  = 1'b1;
    bus.br_target_i = 32'h200;
    step(); chk_out("br_run", 32'h200, 1'b1, 1'b0);

    // Wrap at top of address space.
    bus.br_target_i = 32'hFFFF_FFFC;
    step(); chk_out("br_top", 32'hFFFF_FFFC, 1'b1, 1'b0);
    bus.br_valid_i = 1'b0;
    step(); chk_out("wrap", 32'h0, 1'b1, 1'b0);
    step(); chk_out("wrap_inc", 32'h4, 1'b1, 1'b0);

    // Redirect beats a not-ready memory, then hold at 0x40.
    bus.req_ready_i = 1'b0;
    bus.br_valid_i  = 1'b1;
    bus.br_target_i = 32'h40;
    step(); chk_out("br_notready", 32'h40, 1'b1, 1'b0);
    bus.br_valid_i = 1'b0;
    step(); chk_out("hold40", 32'h40, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    #2 rst = 1'b0;
    #1;
    chk_out("async_rst", 32'h0, 1'b0, 1'b0);
    step(); chk_out("rst_held", 32'h0, 1'b0, 1'b0);

    // Release with a redirect pending during BOOT: it must be ignored.
    bus.req_ready_i = 1'b1;
    bus.br_valid_i  = 1'b1;
    bus.br_target_i = 32'h300;
    #1 rst = 1'b1;
    #1;
    chk_out("reboot", 32'h0, 1'b0, 1'b0);
    step(); chk_out("reboot0", 32'h0, 1'b1, 1'b0);
    bus.br_valid_i = 1'b0;
    step(); chk_out("reboot4", 32'h4, 1'b1, 1'b0);
    step(); chk_out("reboot8", 32'h8, 1'b1, 1'b0);
    step(); chk_out("rebootc", 32'hC, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
